buffer_to_mpf_wr_ctrl: RTL and testbench
========================================

Name: buffer_to_mpf_wr_ctrl

Overview:
Sequences the write side of the generic processing datapath: drains 512-bit lines from the 64-to-512 write buffer and issues one CCI-P WrLine request per line to consecutive destination cache-line addresses. Throttles on c1TxAlmFull and on an outstanding-write credit limit, and counts write responses. Asserts done only after every issued write is acknowledged. Sits between buffer_64_to_512 and the MPF c1 channel, mirroring mpf_to_buffer_SM on the read side.

Parameters:
CL_ADDR_W, 42, width of cache-line address (t_cci_clAddr)
LEN_W, 64, width of data_length in bytes
MAX_OUTSTANDING, 64, maximum unacknowledged write lines (power of 2, >=4)
MDATA_W, 16, width of request mdata tag

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
run  in  1  start pulse; sampled in IDLE only
data_length  in  LEN_W  transfer length in bytes; sampled with run
first_clAddr  in  CL_ADDR_W  destination base line address; sampled with run
buffer_empty  in  1  write buffer has no full 512-bit line
buffer_rd_enable  out  1  pop one line; buffer data_out valid next cycle
c1TxAlmFull  in  1  c1 request channel almost full
wr_valid  out  1  write request valid (drives c1Tx.valid)
wr_clAddr  out  CL_ADDR_W  line address of request
wr_mdata  out  MDATA_W  request tag = low bits of line index
wr_rsp_valid  in  1  c1Rx write response valid
wr_rsp_lines  in  3  lines acknowledged by response, 1..4 (cl_num+1, packed format)
busy  out  1  high in ISSUE or DRAIN
done  out  1  one-cycle completion pulse
rsp_error  out  1  sticky: response while IDLE, or acknowledged lines exceed outstanding count

Behaviour:
- Reset (rst=0, async): state IDLE, all counters 0; buffer_rd_enable, wr_valid, busy, done, rsp_error = 0; wr_clAddr, wr_mdata = 0.
- total_lines = ceil(data_length/64) = (data_length+63)>>6, computed in LEN_W+1 bits so there is no overflow at max length. Latched on run.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - run=1 and total_lines>0 -> ISSUE. Latch base address, clear issued/acked counters, clear rsp_error.
  - run=1 and total_lines=0 -> DONE directly.
- ISSUE:
  - buffer_rd_enable (combinational) = !buffer_empty && !c1TxAlmFull && outstanding<MAX_OUTSTANDING && issued<total_lines.
  - Pop cycle N -> wr_valid=1 in cycle N+1 (registered). wr_clAddr = base+issued (value at N); wr_mdata = issued[MDATA_W-1:0]. issued increments at N.
  - Transition to DRAIN when issued reaches total_lines.
- DRAIN: wait until acked == total_lines -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE. busy=0 in DONE.
- outstanding = issued - acked, kept as a dedicated counter. Update each cycle is +1 on pop and -wr_rsp_lines on response; pop and response in the same cycle apply both.
- Address arithmetic is modulo 2^CL_ADDR_W (wraps silently).
- run while busy or in DONE: ignored, no state change.
- rsp_error handling: response in IDLE, or wr_rsp_lines > outstanding+pop. The offending response is ignored and the counter saturates at 0; rsp_error stays set until the next accepted run.
- c1TxAlmFull rising while a pop is in flight: the already-popped line is still issued next cycle (almost-full margin covers it).
- Reset mid-transfer: immediate return to IDLE. Lines still in the buffer are the buffer's responsibility (its clr).

Decomposition:
- Shared package gen_proc_pkg: t_wr_ctrl_state enum, CL_BYTE_IDX_BITS=6, bytes_to_lines function. The read-side SM uses the same function.
- One sub-module: wr_credit_counter (outstanding counter with simultaneous inc/dec-by-N, saturation and error detect), reusable by the read side.

Test Plan:
- data_length=256, base=0x1000, buffer never empty, almFull=0; responses of 1 line, 5 cycles after each request -> 4 requests at 0x1000..0x1003 on consecutive cycles, mdata 0..3, done pulse the cycle after the 4th response.
- data_length=100 -> total_lines=2. data_length=0 -> no wr_valid, done pulses 2 cycles after run.
- MAX_OUTSTANDING=4, length 640, responses withheld -> exactly 4 requests, then a stall. Release a packed response with wr_rsp_lines=4 -> 4 more requests issue. Done follows the final response.
- Toggle c1TxAlmFull and buffer_empty randomly over 64 lines -> no pop while either is asserted. Addresses are strictly sequential with no gaps or duplicates.
- Pop and response in the same cycle, outstanding=3 -> outstanding stays 3. wr_rsp_valid in IDLE -> rsp_error=1, cleared on next run.
- Assert rst low mid-ISSUE -> all outputs 0 the same cycle. A fresh run afterwards restarts at the new base with mdata=0.

Source files
------------

// File: rtl/gen_proc_pkg.sv
// Shared types and helpers for the generic processing datapath controllers.
package gen_proc_pkg;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_ISSUE = 2'd1,
    WR_DRAIN = 2'd2,
    WR_DONE  = 2'd3
  } t_wr_ctrl_state;

  localparam int unsigned CL_BYTE_IDX_BITS = 6;
  // Wide enough that a zero-extended 128-bit byte count plus rounding cannot overflow.
  localparam int unsigned LINE_CALC_W = 130;

  function automatic logic [LINE_CALC_W-1:0] bytes_to_lines(input logic [LINE_CALC_W-1:0] len_bytes);
    return (len_bytes + LINE_CALC_W'((64'd1 << CL_BYTE_IDX_BITS) - 64'd1)) >> CL_BYTE_IDX_BITS;
  endfunction

endpackage

// File: rtl/wr_credit_counter.sv
// Outstanding-line credit counter: +1 on issue, -N on acknowledge, same-cycle safe.
module wr_credit_counter #(
  parameter int unsigned MAX_CREDITS = 64,
  parameter int unsigned DEC_W       = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr_i,
  input  logic                          inc_i,
  input  logic                          dec_valid_i,
  input  logic [DEC_W-1:0]              dec_n_i,
  output logic [$clog2(MAX_CREDITS):0]  count_o,
  output logic                          dec_ok_c,
  output logic                          dec_err_c
);

  localparam int unsigned CNT_W = $clog2(MAX_CREDITS) + 1;
  localparam int unsigned SUM_W = ((CNT_W > DEC_W) ? CNT_W : DEC_W) + 1;

  logic [CNT_W-1:0] count_q, count_d;
  logic [SUM_W-1:0] sum_c, dec_c;

  // An acknowledge larger than what is in flight is dropped, leaving only the increment.
  always_comb begin
    sum_c     = SUM_W'(count_q) + SUM_W'(inc_i);
    dec_c     = SUM_W'(dec_n_i);
    dec_err_c = dec_valid_i && (dec_c > sum_c);
    dec_ok_c  = dec_valid_i && !dec_err_c;
    count_d   = CNT_W'(sum_c);
    if (clr_i) begin
      count_d = '0;
    end else if (dec_ok_c) begin
      count_d = CNT_W'(sum_c - dec_c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/buffer_to_mpf_wr_ctrl.sv
// Drains 512-bit lines from the write buffer into sequential CCI-P WrLine requests
// and waits for every line to be acknowledged before pulsing done.
module buffer_to_mpf_wr_ctrl
  import gen_proc_pkg::*;
#(
  parameter int unsigned CL_ADDR_W       = 42,
  parameter int unsigned LEN_W           = 64,
  parameter int unsigned MAX_OUTSTANDING = 64,
  parameter int unsigned MDATA_W         = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [LEN_W-1:0]     data_length,
  input  logic [CL_ADDR_W-1:0] first_clAddr,
  input  logic                 buffer_empty,
  output logic                 buffer_rd_enable,
  input  logic                 c1TxAlmFull,
  output logic                 wr_valid,
  output logic [CL_ADDR_W-1:0] wr_clAddr,
  output logic [MDATA_W-1:0]   wr_mdata,
  input  logic                 wr_rsp_valid,
  input  logic [2:0]           wr_rsp_lines,
  output logic                 busy,
  output logic                 done,
  output logic                 rsp_error
);

  localparam int unsigned LINES_W = LEN_W + 1;
  localparam int unsigned CNT_W   = $clog2(MAX_OUTSTANDING) + 1;

  t_wr_ctrl_state       state_q, state_d;
  logic [LINES_W-1:0]   total_q, total_d, issued_q, issued_d, acked_q, acked_d;
  logic [LINES_W-1:0]   run_lines_c;
  logic [CL_ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
  logic [MDATA_W-1:0]   mdata_q, mdata_d;
  logic                 wr_valid_q, wr_valid_d;
  logic                 busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                 pop_c, run_ok_c, cnt_clr_c, rsp_active_c;
  logic                 dec_ok_c, dec_err_c;
  logic [CNT_W-1:0]     outstanding_c;

  assign run_lines_c  = LINES_W'(bytes_to_lines(LINE_CALC_W'(data_length)));
  assign rsp_active_c = wr_rsp_valid && (state_q != WR_IDLE);

  wr_credit_counter #(
    .MAX_CREDITS (MAX_OUTSTANDING),
    .DEC_W       (3)
  ) u_credit (
    .clk         (clk),
    .rst_n       (rst),
    .clr_i       (cnt_clr_c),
    .inc_i       (pop_c),
    .dec_valid_i (rsp_active_c),
    .dec_n_i     (wr_rsp_lines),
    .count_o     (outstanding_c),
    .dec_ok_c    (dec_ok_c),
    .dec_err_c   (dec_err_c)
  );

  // Next-state, pop decision and request datapath.
  always_comb begin
    state_d    = state_q;
    total_d    = total_q;
    issued_d   = issued_q;
    acked_d    = acked_q;
    base_d     = base_q;
    addr_d     = addr_q;
    mdata_d    = mdata_q;
    wr_valid_d = 1'b0;
    err_d      = err_q;
    pop_c      = 1'b0;
    run_ok_c   = 1'b0;
    cnt_clr_c  = 1'b0;

    if (dec_ok_c) begin
      acked_d = acked_q + LINES_W'(wr_rsp_lines);
    end

    case (state_q)
      WR_IDLE: begin
        if (run) begin
          run_ok_c  = 1'b1;
          cnt_clr_c = 1'b1;
          total_d   = run_lines_c;
          base_d    = first_clAddr;
          issued_d  = '0;
          acked_d   = '0;
          state_d   = (run_lines_c == '0) ? WR_DONE : WR_ISSUE;
        end
      end
      WR_ISSUE: begin
        pop_c = !buffer_empty && !c1TxAlmFull &&
                (outstanding_c < CNT_W'(MAX_OUTSTANDING)) && (issued_q < total_q);
        if (pop_c) begin
          wr_valid_d = 1'b1;
          addr_d     = base_q + CL_ADDR_W'(issued_q);
          mdata_d    = MDATA_W'(issued_q);
          issued_d   = issued_q + LINES_W'(1);
        end
        if (issued_q == total_q) begin
          state_d = WR_DRAIN;
        end
      end
      WR_DRAIN: begin
        if (acked_d == total_q) begin
          state_d = WR_DONE;
        end
      end
      WR_DONE: begin
        state_d = WR_IDLE;
      end
      default: begin
        state_d = WR_IDLE;
      end
    endcase

    if (run_ok_c) begin
      err_d = 1'b0;
    end
    if (wr_rsp_valid && ((state_q == WR_IDLE) || dec_err_c)) begin
      err_d = 1'b1;
    end

    busy_d = (state_d == WR_ISSUE) || (state_d == WR_DRAIN);
    done_d = (state_d == WR_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= WR_IDLE;
      total_q    <= '0;
      issued_q   <= '0;
      acked_q    <= '0;
      base_q     <= '0;
      addr_q     <= '0;
      mdata_q    <= '0;
      wr_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      issued_q   <= issued_d;
      acked_q    <= acked_d;
      base_q     <= base_d;
      addr_q     <= addr_d;
      mdata_q    <= mdata_d;
      wr_valid_q <= wr_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign buffer_rd_enable = pop_c;
  assign wr_valid         = wr_valid_q;
  assign wr_clAddr        = addr_q;
  assign wr_mdata         = mdata_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign rsp_error        = err_q;

endmodule

// File: tb/tb_buffer_to_mpf_wr_ctrl.sv
// Scoreboard bench for buffer_to_mpf_wr_ctrl with a four-line credit limit.
module tb_buffer_to_mpf_wr_ctrl;

  localparam int unsigned CL_ADDR_W = 42;
  localparam int unsigned LEN_W     = 64;
  localparam int unsigned MAX_OUT   = 4;
  localparam int unsigned MDATA_W   = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 run;
  logic [LEN_W-1:0]     data_length;
  logic [CL_ADDR_W-1:0] first_clAddr;
  logic                 buffer_empty;
  logic                 buffer_rd_enable;
  logic                 c1TxAlmFull;
  logic                 wr_valid;
  logic [CL_ADDR_W-1:0] wr_clAddr;
  logic [MDATA_W-1:0]   wr_mdata;
  logic                 wr_rsp_valid;
  logic [2:0]           wr_rsp_lines;
  logic                 busy, done, rsp_error;

  always #5 clk = ~clk;

  buffer_to_mpf_wr_ctrl #(
    .CL_ADDR_W       (CL_ADDR_W),
    .LEN_W           (LEN_W),
    .MAX_OUTSTANDING (MAX_OUT),
    .MDATA_W         (MDATA_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .run              (run),
    .data_length      (data_length),
    .first_clAddr     (first_clAddr),
    .buffer_empty     (buffer_empty),
    .buffer_rd_enable (buffer_rd_enable),
    .c1TxAlmFull      (c1TxAlmFull),
    .wr_valid         (wr_valid),
    .wr_clAddr        (wr_clAddr),
    .wr_mdata         (wr_mdata),
    .wr_rsp_valid     (wr_rsp_valid),
    .wr_rsp_lines     (wr_rsp_lines),
    .busy             (busy),
    .done             (done),
    .rsp_error        (rsp_error)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [CL_ADDR_W-1:0] exp_addr_q[$];
  logic [MDATA_W-1:0]   exp_md_q[$];
  int  rsp_due_q[$];
  int  rsp_mode = 0;     // 0 forced only, 1 one line 5 cycles after each request, 2 bulk
  bit  rand_mode = 1'b0;
  bit  run_req = 1'b0;
  int  force_lines = 0;
  int  reqs_seen, acks_sent, last_rsp_cyc, first_req_cyc, last_req_cyc;
  int  done_cnt, done_cyc, run_cyc, n_lines;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive inputs just after the rising edge, sample at the falling edge.
  task automatic step();
    int lines;
    @(posedge clk);
    #1;
    cyc++;
    run     = run_req;
    run_req = 1'b0;
    wr_rsp_valid = 1'b0;
    wr_rsp_lines = 3'd0;
    lines = 0;
    if (force_lines != 0) begin
      lines = force_lines;
      force_lines = 0;
    end else if (rsp_mode == 1 && rsp_due_q.size() != 0 && rsp_due_q[0] <= cyc) begin
      void'(rsp_due_q.pop_front());
      lines = 1;
    end else if (rsp_mode == 2 && reqs_seen > acks_sent) begin
      lines = reqs_seen - acks_sent;
      if (lines > 4) lines = 4;
      lines = int'($urandom_range(1, lines));
    end
    if (lines != 0) begin
      wr_rsp_valid = 1'b1;
      wr_rsp_lines = 3'(lines);
      acks_sent   += lines;
      last_rsp_cyc = cyc;
    end
    if (rand_mode) begin
      buffer_empty = ($urandom_range(0, 2) == 0);
      c1TxAlmFull  = ($urandom_range(0, 3) == 0);
    end
    #4;
    if (buffer_rd_enable)
      check_eq("pop_gate", {62'd0, buffer_empty, c1TxAlmFull}, 64'd0);
    if (wr_valid) begin
      if (reqs_seen == 0) first_req_cyc = cyc;
      last_req_cyc = cyc;
      reqs_seen++;
      check_eq("req_expected", 64'(exp_addr_q.size() != 0), 64'd1);
      if (exp_addr_q.size() != 0) begin
        check_eq("wr_clAddr", 64'(wr_clAddr), 64'(exp_addr_q.pop_front()));
        check_eq("wr_mdata", 64'(wr_mdata), 64'(exp_md_q.pop_front()));
      end
      check_eq("outstanding_le_max", 64'((reqs_seen - acks_sent) <= int'(MAX_OUT)), 64'd1);
      if (rsp_mode == 1) rsp_due_q.push_back(cyc + 5);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic start_run(input logic [LEN_W-1:0] len, input logic [CL_ADDR_W-1:0] base);
    n_lines = int'(len / 64) + ((len % 64 != 0) ? 1 : 0);
    exp_addr_q.delete();
    exp_md_q.delete();
    rsp_due_q.delete();
    for (int i = 0; i < n_lines; i++) begin
      exp_addr_q.push_back(base + CL_ADDR_W'(i));
      exp_md_q.push_back(MDATA_W'(i));
    end
    reqs_seen = 0;
    acks_sent = 0;
    done_cnt  = 0;
    data_length  = len;
    first_clAddr = base;
    run_req = 1'b1;
    step();
    run_cyc = cyc;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      step();
      k++;
    end
    check_eq({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
  endtask

  task automatic end_checks(input string tag);
    check_eq({tag, "_reqs"}, 64'(reqs_seen), 64'(n_lines));
    check_eq({tag, "_acks"}, 64'(acks_sent), 64'(n_lines));
    check_eq({tag, "_sb_empty"}, 64'(exp_addr_q.size()), 64'd0);
    check_eq({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    step();
    step();
    check_eq({tag, "_done_width"}, 64'(done_cnt), 64'd1);
  endtask

  initial begin
    rst = 1'b0;
    run = 1'b0;
    data_length = '0;
    first_clAddr = '0;
    buffer_empty = 1'b0;
    c1TxAlmFull = 1'b0;
    wr_rsp_valid = 1'b0;
    wr_rsp_lines = 3'd0;
    #3;
    check_eq("rst_outputs", {58'd0, buffer_rd_enable, wr_valid, busy, done, rsp_error, 1'b0}, 64'd0);
    check_eq("rst_addr", 64'(wr_clAddr), 64'd0);
    check_eq("rst_mdata", 64'(wr_mdata), 64'd0);
    #9;
    rst = 1'b1;
    step();

    // Four lines, single-line responses five cycles after each request.
    rsp_mode = 1;
    start_run(64'd256, 42'h1000);
    wait_done(100, "t256");
    check_eq("t256_back_to_back", 64'(last_req_cyc - first_req_cyc), 64'd3);
    check_eq("t256_done_after_rsp", 64'(done_cyc - last_rsp_cyc), 64'd1);
    end_checks("t256");

    // Partial line rounds up; base at the top of the address space wraps.
    start_run(64'd100, 42'h3FF_FFFF_FFFF);
    wait_done(100, "t100");
    end_checks("t100");

    // Zero length goes straight to DONE.
    start_run(64'd0, 42'h55);
    wait_done(5, "t0");
    check_eq("t0_done_latency", 64'((done_cyc - run_cyc) <= 2), 64'd1);
    end_checks("t0");

    // Credit limit: responses withheld, then released in packed form.
    rsp_mode = 0;
    start_run(64'd640, 42'h40);
    repeat (20) step();
    check_eq("stall_reqs", 64'(reqs_seen), 64'd4);
    check_eq("stall_busy", 64'(busy), 64'd1);
    force_lines = 4;
    repeat (20) step();
    check_eq("release1_reqs", 64'(reqs_seen), 64'd8);
    force_lines = 4;
    repeat (20) step();
    check_eq("release2_reqs", 64'(reqs_seen), 64'd10);
    check_eq("release2_done_early", 64'(done_cnt), 64'd0);
    force_lines = 2;
    wait_done(20, "stall");
    end_checks("stall");

    // 64 lines with randomly toggled empty / almost-full.
    rsp_mode = 1;
    rand_mode = 1'b1;
    start_run(64'd4096, CL_ADDR_W'({$urandom, $urandom}));
    wait_done(3000, "rand");
    rand_mode = 1'b0;
    buffer_empty = 1'b0;
    c1TxAlmFull = 1'b0;
    end_checks("rand");

    // Pop and response in the same cycle with three in flight keeps the count at three.
    rsp_mode = 0;
    buffer_empty = 1'b1;
    start_run(64'd640, 42'h500);
    buffer_empty = 1'b0;
    repeat (3) step();
    force_lines = 1;
    repeat (12) step();
    check_eq("same_cycle_reqs", 64'(reqs_seen), 64'd5);
    check_eq("same_cycle_no_err", 64'(rsp_error), 64'd0);
    rsp_mode = 2;
    wait_done(300, "same_cycle");
    end_checks("same_cycle");

    // Response while idle is flagged and cleared by the next run.
    rsp_mode = 0;
    force_lines = 1;
    step();
    step();
    check_eq("idle_rsp_error", 64'(rsp_error), 64'd1);
    start_run(64'd64, 42'h77);
    step();
    check_eq("run_clears_error", 64'(rsp_error), 64'd0);
    step();
    step();
    // Acknowledging two lines with one in flight is rejected.
    force_lines = 2;
    step();
    acks_sent -= 2;
    step();
    check_eq("overack_error", 64'(rsp_error), 64'd1);
    check_eq("overack_ignored", 64'(done_cnt), 64'd0);
    force_lines = 1;
    wait_done(20, "overack");
    check_eq("overack_sticky", 64'(rsp_error), 64'd1);
    end_checks("overack");

    // Reset in the middle of issuing, then a fresh run at a new base.
    rsp_mode = 1;
    start_run(64'd640, 42'h9000);
    repeat (3) step();
    #1;
    rst = 1'b0;
    #1;
    check_eq("midrst_outputs", {58'd0, buffer_rd_enable, wr_valid, busy, done, rsp_error, 1'b0}, 64'd0);
    check_eq("midrst_addr", 64'(wr_clAddr), 64'd0);
    check_eq("midrst_mdata", 64'(wr_mdata), 64'd0);
    exp_addr_q.delete();
    exp_md_q.delete();
    step();
    #2;
    rst = 1'b1;
    step();
    start_run(64'd192, 42'h2000);
    wait_done(100, "after_rst");
    end_checks("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
